hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 32: width of the stall-cycle performance counter.
REQ-002 SHALL have parameter FLUSH_CNT_W, default 16: width of the branch-flush performance counter.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: the reset, synchronous and active-high.
REQ-005 SHALL have port idex_MemRead_out, input, 1: the instruction in EX is a load.
REQ-006 SHALL have port idex_wsel_out, input, regbits_t: destination register of the instruction in EX.
REQ-007 SHALL have ports ifid_rs_out and ifid_rt_out, input, regbits_t: source registers of the instruction in ID.
REQ-008 SHALL have port ifid_uses_rt, input, 1: the instruction in ID reads rt; low for I-type non-store.
REQ-009 SHALL have port exmem_branch_taken, input, 1: a branch or jump resolved taken in MEM.
REQ-010 SHALL have ports exmem_dmemreq and dhit, input, 1 each: data request pending in MEM; datapath hit.
REQ-011 SHALL have port ihit, input, 1: instruction fetch complete.
REQ-012 SHALL have port memwb_halt_out, input, 1: a halt has reached WB.
REQ-013 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en, memwb_en, 1 each: stage-advance enables.
REQ-014 SHALL have outputs ifid_flush, idex_flush, exmem_flush, memwb_flush, 1 each: insert a bubble into that register.
REQ-015 SHALL have output state_out, hazard_state_t: current FSM state.
REQ-016 SHALL have outputs stall_cycles (STALL_CNT_W) and flush_count (FLUSH_CNT_W): performance counters.

Function
REQ-017 SHALL implement FSM states RUN, DWAIT and HALTED.
REQ-018 RUN SHALL go to DWAIT when exmem_dmemreq and not dhit; DWAIT SHALL go to RUN on dhit.
REQ-019 Any state SHALL go to HALTED when memwb_halt_out is high; HALTED SHALL be left only by RST.
REQ-020 Outputs SHALL be combinational from state and inputs, using the first matching priority below.
REQ-021 Priority 1, HALTED: all enables 0 and all flushes 0.
REQ-022 Priority 2, exmem_dmemreq and not dhit, in any non-halted state: pc, ifid, idex and exmem enables 0; memwb_flush 1.
REQ-023 Priority 3, exmem_branch_taken: pc_en 1; ifid_flush, idex_flush and exmem_flush 1; the remaining enables 1.
REQ-024 Priority 4, load-use: when idex_MemRead_out and idex_wsel_out != 0 and (ifid_rs_out == idex_wsel_out or (ifid_uses_rt and ifid_rt_out == idex_wsel_out)), pc_en and ifid_en 0, idex_flush 1, other enables 1.
REQ-025 Priority 5, not ihit: pc_en 0, ifid_flush 1, other enables 1.
REQ-026 Default: all enables 1, all flushes 0.
REQ-027 The unit SHALL add no latency: each hazard is resolved in the cycle it is presented.
REQ-028 A load-use match on register 0 SHALL NOT stall.
REQ-029 stall_cycles SHALL increment by 1 each non-halted cycle in which pc_en is 0, and SHALL wrap modulo 2^STALL_CNT_W.
REQ-030 flush_count SHALL increment on each cycle in which priority 3 applies, and SHALL saturate at all-ones.
REQ-031 When memwb_halt_out and a hazard occur in the same cycle, the hazard outputs SHALL apply that cycle; HALTED takes effect the next cycle.

Reset
REQ-032 On RST high at a clock edge: state RUN, stall_cycles 0, flush_count 0.
REQ-033 Combinational outputs after reset SHALL follow the RUN priority rules.
REQ-034 RST high while in DWAIT or HALTED SHALL return the state to RUN and clear both counters.

Structure
REQ-035 hazard_state_t (RUN, DWAIT, HALTED) SHALL be added to cpu_types_pkg.
REQ-036 Ports SHALL be bundled in interface hazard_unit_if (include/hazard_unit_if.vh), with modport hu for the unit and modport tb for the bench.
REQ-037 One sub-module, hazard_perf_counter, SHALL implement both counters, parameterised by width and wrap/saturate mode.

Verification
REQ-038 Load-use: idex_MemRead_out=1, idex_wsel_out=5, ifid_rs_out=5 -> pc_en=0, ifid_en=0, idex_flush=1; stall_cycles rises by 1.
REQ-039 Zero register: idex_wsel_out=0, ifid_rs_out=0, load in EX -> no stall.
REQ-040 Data wait: exmem_dmemreq=1 with dhit=0 for 3 cycles, then dhit=1 -> state DWAIT for 3 cycles, memwb_flush=1 during the wait, then RUN; stall_cycles=3.
REQ-041 Branch vs load-use in the same cycle -> branch wins: three flushes, pc_en=1; flush_count=1.
REQ-042 Saturation: FLUSH_CNT_W=2 with 5 taken branches -> flush_count=3.
REQ-043 Halt: memwb_halt_out pulsed once -> state HALTED, all enables 0 until RST=1, then state RUN and both counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard FSM state and the load-use match rule.
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic     mem_read,
        input regbits_t wsel,
        input regbits_t rs,
        input regbits_t rt,
        input logic     uses_rt
    );
        return mem_read && (wsel != '0) && ((rs == wsel) || (uses_rt && (rt == wsel)));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline hazard unit and its environment.
interface hazard_unit_if #(
    parameter int unsigned STALL_CNT_W = 32,
    parameter int unsigned FLUSH_CNT_W = 16
) (
    input logic CLK
);
    import cpu_types_pkg::*;

    logic                   RST;
    logic                   idex_MemRead_out;
    regbits_t               idex_wsel_out;
    regbits_t               ifid_rs_out;
    regbits_t               ifid_rt_out;
    logic                   ifid_uses_rt;
    logic                   exmem_branch_taken;
    logic                   exmem_dmemreq;
    logic                   dhit;
    logic                   ihit;
    logic                   memwb_halt_out;

    logic                   pc_en;
    logic                   ifid_en;
    logic                   idex_en;
    logic                   exmem_en;
    logic                   memwb_en;
    logic                   ifid_flush;
    logic                   idex_flush;
    logic                   exmem_flush;
    logic                   memwb_flush;
    hazard_state_t          state_out;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic [FLUSH_CNT_W-1:0] flush_count;

    modport hu (
        input  CLK, RST, idex_MemRead_out, idex_wsel_out, ifid_rs_out, ifid_rt_out,
               ifid_uses_rt, exmem_branch_taken, exmem_dmemreq, dhit, ihit, memwb_halt_out,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               state_out, stall_cycles, flush_count
    );

    modport tb (
        input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               state_out, stall_cycles, flush_count,
        output RST, idex_MemRead_out, idex_wsel_out, ifid_rs_out, ifid_rt_out,
               ifid_uses_rt, exmem_branch_taken, exmem_dmemreq, dhit, ihit, memwb_halt_out
    );

endinterface

// File: rtl/hazard_perf_counter.sv
// Event counter with synchronous reset; wraps or saturates depending on SATURATE.
module hazard_perf_counter #(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !(SATURATE && at_max)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: combinational stall/flush control plus a RUN/DWAIT/HALTED FSM.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32,
    parameter int unsigned FLUSH_CNT_W = 16
) (
    hazard_unit_if.hu bus
);

    hazard_state_t state_q;
    hazard_state_t state_d;

    logic data_wait;
    logic load_use;
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
    logic branch_flush;
    logic stall_inc;

    assign data_wait = bus.exmem_dmemreq && !bus.dhit;
    assign load_use  = load_use_hit(bus.idex_MemRead_out, bus.idex_wsel_out,
                                    bus.ifid_rs_out, bus.ifid_rt_out, bus.ifid_uses_rt);

    always_ff @(posedge bus.CLK) begin
        if (bus.RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (data_wait) state_d = DWAIT;
            DWAIT:   if (bus.dhit)  state_d = RUN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
        // A halt overrides any other transition; it only takes effect next cycle.
        if (bus.memwb_halt_out) begin
            state_d = HALTED;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        branch_flush = 1'b0;
        if (state_q == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (data_wait) begin
            // Freeze up to MEM and let a bubble drain into WB.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (bus.exmem_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            branch_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!bus.ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign stall_inc = (state_q != HALTED) && !pc_en;

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.state_out   = state_q;

    hazard_perf_counter #(
        .WIDTH    (STALL_CNT_W),
        .SATURATE (1'b0)
    ) u_stall_cnt (
        .clk   (bus.CLK),
        .rst   (bus.RST),
        .inc   (stall_inc),
        .count (bus.stall_cycles)
    );

    hazard_perf_counter #(
        .WIDTH    (FLUSH_CNT_W),
        .SATURATE (1'b1)
    ) u_flush_cnt (
        .clk   (bus.CLK),
        .rst   (bus.RST),
        .inc   (branch_flush),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (default widths plus a 2-bit counter instance).
module tb_hazard_unit;
    import cpu_types_pkg::*;

    // Output vector order: pc, ifid, idex, exmem, memwb enables; ifid, idex, exmem, memwb flushes
    localparam logic [8:0] O_DEF    = 9'b11111_0000;
    localparam logic [8:0] O_LU     = 9'b00111_0100;
    localparam logic [8:0] O_IMISS  = 9'b01111_1000;
    localparam logic [8:0] O_DWAIT  = 9'b00001_0001;
    localparam logic [8:0] O_BRANCH = 9'b11111_1110;
    localparam logic [8:0] O_HALT   = 9'b00000_0000;

    logic clk = 1'b0;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    hazard_unit_if #(.STALL_CNT_W(32), .FLUSH_CNT_W(16)) hif (.CLK(clk));
    hazard_unit_if #(.STALL_CNT_W(2),  .FLUSH_CNT_W(2))  sif (.CLK(clk));

    hazard_unit #(.STALL_CNT_W(32), .FLUSH_CNT_W(16)) dut     (.bus(hif));
    hazard_unit #(.STALL_CNT_W(2),  .FLUSH_CNT_W(2))  dut_sat (.bus(sif));

    function automatic logic [8:0] outs();
        return {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush};
    endfunction

    task automatic idle();
        hif.RST = 1'b0; hif.idex_MemRead_out = 1'b0; hif.idex_wsel_out = '0;
        hif.ifid_rs_out = '0; hif.ifid_rt_out = '0; hif.ifid_uses_rt = 1'b0;
        hif.exmem_branch_taken = 1'b0; hif.exmem_dmemreq = 1'b0; hif.dhit = 1'b0;
        hif.ihit = 1'b1; hif.memwb_halt_out = 1'b0;
        sif.RST = 1'b0; sif.idex_MemRead_out = 1'b0; sif.idex_wsel_out = '0;
        sif.ifid_rs_out = '0; sif.ifid_rt_out = '0; sif.ifid_uses_rt = 1'b0;
        sif.exmem_branch_taken = 1'b0; sif.exmem_dmemreq = 1'b0; sif.dhit = 1'b0;
        sif.ihit = 1'b1; sif.memwb_halt_out = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        hif.RST = 1'b1;
        sif.RST = 1'b1;
        step();
        hif.RST = 1'b0;
        sif.RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (outs() !== O_DEF) $display("FAIL reset_outs: got %b want %b", outs(), O_DEF);
        else passed++;
        total++; if (hif.state_out !== RUN) $display("FAIL reset_state: got %0d want %0d", hif.state_out, RUN);
        else passed++;
        total++; if (hif.stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d want 0", hif.stall_cycles);
        else passed++;
        total++; if (hif.flush_count !== 16'd0) $display("FAIL reset_flush: got %0d want 0", hif.flush_count);
        else passed++;
    endtask

    task automatic test_load_use();
        hif.idex_MemRead_out = 1'b1; hif.idex_wsel_out = 5'd5; hif.ifid_rs_out = 5'd5; #1;
        total++; if (outs() !== O_LU) $display("FAIL lu_rs_outs: got %b want %b", outs(), O_LU);
        else passed++;
        step(); idle(); #1;
        total++; if (hif.stall_cycles !== 32'd1) $display("FAIL lu_rs_stall: got %0d want 1", hif.stall_cycles);
        else passed++;
        hif.idex_MemRead_out = 1'b1; hif.idex_wsel_out = 5'd5; hif.ifid_rs_out = 5'd3;
        hif.ifid_rt_out = 5'd5; hif.ifid_uses_rt = 1'b1; #1;
        total++; if (outs() !== O_LU) $display("FAIL lu_rt_outs: got %b want %b", outs(), O_LU);
        else passed++;
        step();
        hif.ifid_uses_rt = 1'b0; #1;
        total++; if (outs() !== O_DEF) $display("FAIL lu_rt_unused_outs: got %b want %b", outs(), O_DEF);
        else passed++;
        step(); idle(); #1;
        total++; if (hif.stall_cycles !== 32'd2) $display("FAIL lu_rt_stall: got %0d want 2", hif.stall_cycles);
        else passed++;
    endtask

    task automatic test_zero_reg();
        hif.idex_MemRead_out = 1'b1; hif.idex_wsel_out = 5'd0; hif.ifid_rs_out = 5'd0;
        hif.ifid_rt_out = 5'd0; hif.ifid_uses_rt = 1'b1; #1;
        total++; if (outs() !== O_DEF) $display("FAIL zero_reg_outs: got %b want %b", outs(), O_DEF);
        else passed++;
        hif.idex_MemRead_out = 1'b0; hif.idex_wsel_out = 5'd5; hif.ifid_rs_out = 5'd5; #1;
        total++; if (outs() !== O_DEF) $display("FAIL no_load_outs: got %b want %b", outs(), O_DEF);
        else passed++;
        step(); idle(); #1;
        total++; if (hif.stall_cycles !== 32'd2) $display("FAIL zero_reg_stall: got %0d want 2", hif.stall_cycles);
        else passed++;
    endtask

    task automatic test_ihit();
        hif.ihit = 1'b0; #1;
        total++; if (outs() !== O_IMISS) $display("FAIL imiss_outs: got %b want %b", outs(), O_IMISS);
        else passed++;
        step(); idle(); #1;
        total++; if (hif.stall_cycles !== 32'd3) $display("FAIL imiss_stall: got %0d want 3", hif.stall_cycles);
        else passed++;
    endtask

    task automatic test_dwait();
        do_reset();
        hif.exmem_dmemreq = 1'b1; hif.dhit = 1'b0; #1;
        total++; if (outs() !== O_DWAIT) $display("FAIL dwait_c0_outs: got %b want %b", outs(), O_DWAIT);
        else passed++;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i == 3) hif.dhit = 1'b1;
            #1;
            total++; if (hif.state_out !== DWAIT)
                $display("FAIL dwait_state_c%0d: got %0d want %0d", i, hif.state_out, DWAIT);
            else passed++;
            total++; if (outs() !== ((i < 3) ? O_DWAIT : O_DEF))
                $display("FAIL dwait_outs_c%0d: got %b want %b", i, outs(), (i < 3) ? O_DWAIT : O_DEF);
            else passed++;
        end
        step(); idle(); #1;
        total++; if (hif.state_out !== RUN) $display("FAIL dwait_exit_state: got %0d want %0d", hif.state_out, RUN);
        else passed++;
        total++; if (hif.stall_cycles !== 32'd3) $display("FAIL dwait_stall: got %0d want 3", hif.stall_cycles);
        else passed++;
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        hif.exmem_branch_taken = 1'b1;
        hif.idex_MemRead_out = 1'b1; hif.idex_wsel_out = 5'd5; hif.ifid_rs_out = 5'd5; #1;
        total++; if (outs() !== O_BRANCH) $display("FAIL branch_lu_outs: got %b want %b", outs(), O_BRANCH);
        else passed++;
        step(); idle(); #1;
        total++; if (hif.flush_count !== 16'd1) $display("FAIL branch_flush_cnt: got %0d want 1", hif.flush_count);
        else passed++;
        total++; if (hif.stall_cycles !== 32'd0) $display("FAIL branch_stall: got %0d want 0", hif.stall_cycles);
        else passed++;
    endtask

    task automatic test_back_to_back();
        hif.exmem_branch_taken = 1'b1; hif.exmem_dmemreq = 1'b1; hif.dhit = 1'b0; #1;
        total++; if (outs() !== O_DWAIT) $display("FAIL b2b_dwait_outs: got %b want %b", outs(), O_DWAIT);
        else passed++;
        step();
        hif.dhit = 1'b1; #1;
        total++; if (outs() !== O_BRANCH) $display("FAIL b2b_branch_outs: got %b want %b", outs(), O_BRANCH);
        else passed++;
        step(); idle(); #1;
        total++; if (hif.flush_count !== 16'd2) $display("FAIL b2b_flush_cnt: got %0d want 2", hif.flush_count);
        else passed++;
        total++; if (hif.stall_cycles !== 32'd1) $display("FAIL b2b_stall: got %0d want 1", hif.stall_cycles);
        else passed++;
        total++; if (hif.state_out !== RUN) $display("FAIL b2b_state: got %0d want %0d", hif.state_out, RUN);
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        sif.exmem_branch_taken = 1'b1;
        repeat (5) step();
        sif.exmem_branch_taken = 1'b0; #1;
        total++; if (sif.flush_count !== 2'd3) $display("FAIL flush_saturate: got %0d want 3", sif.flush_count);
        else passed++;
        sif.ihit = 1'b0;
        repeat (5) step();
        sif.ihit = 1'b1; #1;
        total++; if (sif.stall_cycles !== 2'd1) $display("FAIL stall_wrap: got %0d want 1", sif.stall_cycles);
        else passed++;
    endtask

    task automatic test_halt();
        do_reset();
        hif.memwb_halt_out = 1'b1; hif.ihit = 1'b0; #1;
        total++; if (outs() !== O_IMISS) $display("FAIL halt_same_cycle_outs: got %b want %b", outs(), O_IMISS);
        else passed++;
        total++; if (hif.state_out !== RUN) $display("FAIL halt_same_cycle_state: got %0d want %0d", hif.state_out, RUN);
        else passed++;
        step();
        hif.memwb_halt_out = 1'b0; #1;
        total++; if (hif.state_out !== HALTED) $display("FAIL halt_state: got %0d want %0d", hif.state_out, HALTED);
        else passed++;
        total++; if (outs() !== O_HALT) $display("FAIL halt_outs: got %b want %b", outs(), O_HALT);
        else passed++;
        hif.exmem_dmemreq = 1'b1;
        repeat (3) step();
        total++; if (hif.state_out !== HALTED) $display("FAIL halt_sticky: got %0d want %0d", hif.state_out, HALTED);
        else passed++;
        total++; if (hif.stall_cycles !== 32'd1) $display("FAIL halt_stall_frozen: got %0d want 1", hif.stall_cycles);
        else passed++;
        hif.RST = 1'b1;
        step();
        idle(); #1;
        total++; if (hif.state_out !== RUN) $display("FAIL halt_reset_state: got %0d want %0d", hif.state_out, RUN);
        else passed++;
        total++; if (hif.stall_cycles !== 32'd0) $display("FAIL halt_reset_stall: got %0d want 0", hif.stall_cycles);
        else passed++;
        total++; if (hif.flush_count !== 16'd0) $display("FAIL halt_reset_flush: got %0d want 0", hif.flush_count);
        else passed++;
        total++; if (outs() !== O_DEF) $display("FAIL halt_reset_outs: got %b want %b", outs(), O_DEF);
        else passed++;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_ihit();
        test_dwait();
        test_branch_vs_load_use();
        test_back_to_back();
        test_saturation();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
